psum_seq_ctrl: RTL
==================

Name: psum_seq_ctrl

Overview:
- Sequencer for the 3-stage psum adder tree (pe0..pe3 pair-sums -> sum -> +fifo_data -> out).
- Tracks pass (input-channel group) and column counters across a multi-pass accumulation of one output row.
- Drives the psum FIFO read/write strobes and the zero-select for the first pass, aligned to the adder pipeline.
- Routes the adder output either back to the psum FIFO (intermediate pass) or downstream (final pass).

Parameters:
- LEN_W, 10, width of row-length config and column counter
- PASS_W, 8, width of pass-count config and pass counter

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; latches cfg_* and begins a job
- cfg_row_len  in  LEN_W  psum beats per pass (W)
- cfg_num_pass  in  PASS_W  passes per job (C)
- pe_valid  in  1  PE outputs valid on pe0..pe3 this cycle
- fifo_empty  in  1  psum FIFO empty
- fifo_full  in  1  psum FIFO full
- fifo_rd_en  out  1  psum FIFO pop; read data appears one cycle later
- fifo_zero_sel  out  1  1 = force adder fifo operand to zero
- fifo_wr_en  out  1  push adder out into psum FIFO
- out_valid  out  1  adder out is a final result
- busy  out  1  job in progress (RUN or DRAIN)
- done  out  1  one-cycle pulse after the last final result
- cur_pass  out  PASS_W  pass index of beats currently being accepted
- err_underflow  out  1  sticky; FIFO read while empty
- err_overflow  out  1  sticky; FIFO write while full, or excess pe_valid

Behaviour:
- Reset (rst=1 at edge): state=IDLE; all outputs 0; counters, pipeline tags and sticky errors cleared. Applies mid-job; in-flight beats are discarded with no strobes.
- States:
  - IDLE: start with cfg_row_len!=0 and cfg_num_pass!=0 latches W and C, sets col=0, pass=0 -> RUN. A start carrying a zero config is ignored (stay IDLE).
  - RUN: each pe_valid beat is accepted; col increments. At col==W-1: col=0, pass++. On the beat with pass==C-1 and col==W-1 -> DRAIN.
  - DRAIN: wait until the pipeline valid tags are empty, then pulse done for one cycle -> IDLE.
- start outside IDLE is ignored. pe_valid in IDLE is ignored. pe_valid in DRAIN sets err_overflow and is otherwise ignored.
- busy=1 in RUN and DRAIN.
- Pipeline alignment, for a beat accepted at cycle t (adder latency 3):
  - t+1: if the beat's pass!=0, fifo_rd_en=1.
  - t+2: fifo_zero_sel=1 if pass==0, else 0. Held 0 when no tag is present.
  - t+3: out_valid=1 if pass==C-1, otherwise fifo_wr_en=1. When C==1, every beat takes pass 0 and is final: no FIFO traffic.
- Tag shift register: 3 entries of {valid, first, last}; advances every cycle; beats need not be consecutive.
- fifo_rd_en is asserted even when fifo_empty=1; err_underflow latches. Same rule for fifo_wr_en with fifo_full (err_overflow latches). The controller never stalls.
- cur_pass shows the pass of the next accepted beat; 0 in IDLE.
- done asserts the cycle after the last out_valid. Its latency from the final beat is therefore 4 cycles.
- Counters wrap only via config compare, never by overflow. W and C use the full LEN_W/PASS_W range.

Test Plan:
- Reset, then W=4, C=3, 12 back-to-back pe_valid beats:
  - fifo_zero_sel high on cycles t0+2..t0+5.
  - fifo_rd_en on 8 cycles (t0+5..t0+12).
  - fifo_wr_en on cycles t0+3..t0+10.
  - out_valid on cycles t0+11..t0+14.
  - done at t0+15; busy falls the same cycle.
- C=1, W=5, beats with 1-cycle gaps: 5 out_valid pulses, each 3 cycles after its beat; fifo_rd_en and fifo_wr_en never assert; done one cycle after the 5th out_valid.
- W=2, C=2, fifo_empty held 1 during pass 1: fifo_rd_en still pulses twice; err_underflow=1 and remains set until rst.
- start with cfg_row_len=0 -> busy stays 0. start during RUN -> counters unaffected. Extra pe_valid during DRAIN -> err_overflow=1, no extra strobe.
- rst asserted 1 cycle after the 3rd beat of a W=4, C=2 job: next cycle all outputs 0, state IDLE; a new job then runs cleanly.
- W=1023, C=255 (max), random pe_valid gaps: out_valid count=1023, fifo_wr_en count=1023*254, done exactly once.

Source files
------------

// File: rtl/psum_seq_ctrl.sv
// Sequencer for the 3-stage psum adder tree: tracks pass/column over one output row
// and emits FIFO read/write, zero-select and final-output strobes aligned to the adder.
module psum_seq_ctrl #(
    parameter int LEN_W  = 10,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_row_len,
    input  logic [PASS_W-1:0] cfg_num_pass,
    input  logic              pe_valid,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    output logic              fifo_rd_en,
    output logic              fifo_zero_sel,
    output logic              fifo_wr_en,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic [PASS_W-1:0] cur_pass,
    output logic              err_underflow,
    output logic              err_overflow,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    state_t            state_q, state_d;
    tag_t              tag_in, tag1_q, tag2_q;
    logic              t3_valid_q, t3_last_q;
    logic [LEN_W-1:0]  w_q, w_d, col_q, col_d;
    logic [PASS_W-1:0] c_q, c_d, pass_q, pass_d;
    logic              done_q, done_d;
    logic              err_un_q, err_un_d, err_ov_q, err_ov_d;
    logic              start_ok, accept, col_last, pass_last;

    assign start_ok  = start && (cfg_row_len != '0) && (cfg_num_pass != '0);
    assign accept    = (state_q == S_RUN) && pe_valid;
    assign col_last  = (col_q == w_q - LEN_W'(1));
    assign pass_last = (pass_q == c_q - PASS_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Leave DRAIN once nothing is left ahead of stage 3; done is registered so it
    // lands the cycle after the last out_valid, together with the drop of busy.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_RUN;
            S_RUN:   if (accept && col_last && pass_last) state_d = S_DRAIN;
            S_DRAIN: if (!tag1_q.valid && !tag2_q.valid) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q != S_IDLE);
        fifo_rd_en    = tag1_q.valid && !tag1_q.first;
        fifo_zero_sel = tag2_q.valid && tag2_q.first;
        fifo_wr_en    = t3_valid_q && !t3_last_q;
        out_valid     = t3_valid_q && t3_last_q;
        done          = done_q;
        cur_pass      = pass_q;
        err_underflow = err_un_q;
        err_overflow  = err_ov_q;
        dbg_state     = state_q;
    end

    always_comb begin
        w_d    = w_q;
        c_d    = c_q;
        col_d  = col_q;
        pass_d = pass_q;
        if (state_q == S_IDLE && start_ok) begin
            w_d    = cfg_row_len;
            c_d    = cfg_num_pass;
            col_d  = '0;
            pass_d = '0;
        end else if (accept) begin
            if (col_last) begin
                col_d  = '0;
                pass_d = pass_last ? '0 : pass_q + PASS_W'(1);
            end else begin
                col_d = col_q + LEN_W'(1);
            end
        end
    end

    always_comb begin
        tag_in.valid = accept;
        tag_in.first = accept && (pass_q == '0);
        tag_in.last  = accept && pass_last;
        err_un_d     = err_un_q || (fifo_rd_en && fifo_empty);
        err_ov_d     = err_ov_q || (fifo_wr_en && fifo_full)
                       || ((state_q == S_DRAIN) && pe_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q        <= '0;
            c_q        <= '0;
            col_q      <= '0;
            pass_q     <= '0;
            tag1_q     <= '0;
            tag2_q     <= '0;
            t3_valid_q <= 1'b0;
            t3_last_q  <= 1'b0;
            done_q     <= 1'b0;
            err_un_q   <= 1'b0;
            err_ov_q   <= 1'b0;
        end else begin
            w_q        <= w_d;
            c_q        <= c_d;
            col_q      <= col_d;
            pass_q     <= pass_d;
            tag1_q     <= tag_in;
            tag2_q     <= tag1_q;
            t3_valid_q <= tag2_q.valid;
            t3_last_q  <= tag2_q.last;
            done_q     <= done_d;
            err_un_q   <= err_un_d;
            err_ov_q   <= err_ov_d;
        end
    end

endmodule
